// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier controller.
package spm_pkg;

    localparam int unsigned SPM_WIDTH  = 32;
    localparam int unsigned PROD_WIDTH = 2 * SPM_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } spm_state_e;

endpackage

// File: rtl/spm_controller_if.sv
// Bus-side handshakes plus the serial link to the SPM array, as seen by the controller.
interface spm_controller_if
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = SPM_WIDTH
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 busy;
    logic [WIDTH-1:0]     spm_x;
    logic                 spm_clr;
    logic                 spm_en;
    logic                 spm_y_bit;
    logic                 spm_p_bit;

    // Environment side: requester, consumer and datapath.
    modport master (
        output in_valid, in_x, in_y, abort, out_ready, spm_p_bit,
        input  in_ready, out_valid, out_p, busy, spm_x, spm_clr, spm_en, spm_y_bit
    );

    modport slave (
        input  in_valid, in_x, in_y, abort, out_ready, spm_p_bit,
        output in_ready, out_valid, out_p, busy, spm_x, spm_clr, spm_en, spm_y_bit
    );

endinterface

// File: rtl/spm_bit_counter.sv
// Serial bit counter; tc_o flags the last of the 2*WIDTH product bits.
module spm_bit_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(2 * WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    // Terminal count is registered alongside the count so it tracks cnt_q exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/spm_controller.sv
// Sequences one signed SPM multiply: load multiplicand, stream the sign-extended
// multiplier LSB-first for 2*WIDTH cycles, collect product bits, hand result out.
module spm_controller
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = SPM_WIDTH,
    parameter int unsigned CNT_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    spm_controller_if.slave  bus
);

    localparam int unsigned PW = 2 * WIDTH;

    spm_state_e       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [PW-1:0]    p_q, p_d;
    logic             in_ready_q, out_valid_q, busy_q, clr_q, en_q, ybit_q;
    logic             cnt_clr, cnt_en, cnt_tc;

    spm_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_LOAD;
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = bus.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    p_d     = '0;
                end else begin
                    p_d    = {bus.spm_p_bit, p_q[PW-1:1]};
                    y_d    = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                    // Hold at terminal count so the counter never wraps.
                    cnt_en = !cnt_tc;
                    if (cnt_tc) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            clr_q       <= 1'b0;
            en_q        <= 1'b0;
            ybit_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            p_q         <= p_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            clr_q       <= (state_d == ST_LOAD);
            en_q        <= (state_d == ST_RUN);
            ybit_q      <= (state_d == ST_RUN) && y_d[0];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = p_q;
    assign bus.busy      = busy_q;
    assign bus.spm_x     = x_q;
    assign bus.spm_clr   = clr_q;
    assign bus.spm_en    = en_q;
    assign bus.spm_y_bit = ybit_q;

endmodule

// File: tb/tb_spm_controller.sv
// Directed bench for spm_controller with a behavioural serial-parallel multiplier attached.
module tb_spm_controller;
    import spm_pkg::*;

    localparam int unsigned W  = SPM_WIDTH;
    localparam int unsigned PW = PROD_WIDTH;

    logic clk = 1'b0;
    logic rst;

    spm_controller_if bus_if ();

    spm_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural SPM array: partial sum of sign-extended x times each serial y bit.
    logic [PW-1:0] m_acc, m_sum, m_shr;
    logic [6:0]    m_k;

    always_comb begin
        m_sum = m_acc + (bus_if.spm_y_bit ?
                         ({{W{bus_if.spm_x[W-1]}}, bus_if.spm_x} << m_k) : '0);
        m_shr = m_sum >> m_k;
        bus_if.spm_p_bit = m_shr[0];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc <= '0;
            m_k   <= '0;
        end else if (bus_if.spm_clr) begin
            m_acc <= '0;
            m_k   <= '0;
        end else if (bus_if.spm_en) begin
            m_acc <= m_sum;
            m_k   <= m_k + 7'd1;
        end
    end

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [PW-1:0] p;
        int            hold;
    } vec_t;

    vec_t vecs [4];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y, output int waited);
        bus_if.in_x     = x;
        bus_if.in_y     = y;
        bus_if.in_valid = 1'b1;
        waited = 0;
        while (!bus_if.in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk1("accept_timeout", waited < 200, 1'b1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        chk1("load_busy", bus_if.busy, 1'b1);
        chk1("load_clr", bus_if.spm_clr, 1'b1);
        chk1("load_en", bus_if.spm_en, 1'b0);
        chkw("load_spm_x", 64'(bus_if.spm_x), 64'(x));
    endtask

    task automatic run_op(input logic [W-1:0] y, input logic [PW-1:0] exp_p, input int hold,
                          input bit pend, input logic [W-1:0] nx, input logic [W-1:0] ny);
        int            e      = 0;
        int            en_cnt = 0;
        logic [PW-1:0] ybits  = '0;
        logic [PW-1:0] ysext;
        ysext = {{W{y[W-1]}}, y};
        while (!bus_if.out_valid && e < 200) begin
            @(posedge clk); #1;
            e++;
            if (bus_if.spm_en) begin
                if (en_cnt < int'(PW)) ybits[en_cnt] = bus_if.spm_y_bit;
                en_cnt++;
            end
        end
        chkw("latency", 64'(e), 64'(2 * W + 1));
        chkw("en_cycles", 64'(en_cnt), 64'(PW));
        chkw("y_stream", ybits, ysext);
        chkw("out_p", bus_if.out_p, exp_p);
        if (pend) begin
            bus_if.in_x     = nx;
            bus_if.in_y     = ny;
            bus_if.in_valid = 1'b1;
        end
        // abort while DONE must be ignored
        bus_if.abort = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk1("hold_valid", bus_if.out_valid, 1'b1);
            chk1("hold_in_ready", bus_if.in_ready, 1'b0);
            chkw("hold_out_p", bus_if.out_p, exp_p);
        end
        bus_if.abort     = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk1("consumed_valid", bus_if.out_valid, 1'b0);
        chk1("consumed_in_ready", bus_if.in_ready, 1'b1);
        chk1("consumed_busy", bus_if.busy, 1'b0);
    endtask

    initial begin
        int  w;
        bit  seen;

        vecs[0] = '{x: 32'd3,          y: 32'd5,          p: 64'h0000_0000_0000_000F, hold: 0};
        vecs[1] = '{x: 32'd6,          y: 32'hFFFF_FFF9,  p: 64'hFFFF_FFFF_FFFF_FFD6, hold: 2};
        vecs[2] = '{x: 32'h8000_0000,  y: 32'h8000_0000,  p: 64'h4000_0000_0000_0000, hold: 0};
        vecs[3] = '{x: 32'h7FFF_FFFF,  y: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFF_8000_0001, hold: 1};

        bus_if.in_valid  = 1'b0;
        bus_if.in_x      = '0;
        bus_if.in_y      = '0;
        bus_if.abort     = 1'b0;
        bus_if.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", bus_if.in_ready, 1'b1);
        chk1("rst_out_valid", bus_if.out_valid, 1'b0);
        chk1("rst_busy", bus_if.busy, 1'b0);
        chk1("rst_clr", bus_if.spm_clr, 1'b0);
        chk1("rst_en", bus_if.spm_en, 1'b0);
        chk1("rst_ybit", bus_if.spm_y_bit, 1'b0);
        chkw("rst_out_p", bus_if.out_p, 64'h0);
        chkw("rst_spm_x", 64'(bus_if.spm_x), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            accept_op(vecs[i].x, vecs[i].y, w);
            run_op(vecs[i].y, vecs[i].p, vecs[i].hold, 1'b0, '0, '0);
        end

        // Back-pressure with the next request pending, then back-to-back accept.
        accept_op(32'd6, 32'hFFFF_FFF9, w);
        run_op(32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 10, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        accept_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, w);
        chkw("b2b_wait", 64'(w), 64'h0);
        run_op(32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0, 1'b0, '0, '0);

        // Abort at RUN cycle 20.
        accept_op(32'd5, 32'd9, w);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
        end
        chk1("pre_abort_en", bus_if.spm_en, 1'b1);
        bus_if.abort = 1'b1;
        @(posedge clk); #1;
        chk1("abort_in_ready", bus_if.in_ready, 1'b1);
        chk1("abort_busy", bus_if.busy, 1'b0);
        chk1("abort_en", bus_if.spm_en, 1'b0);
        chk1("abort_valid", bus_if.out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (i == 10) bus_if.abort = 1'b0;
            seen = seen | bus_if.out_valid | bus_if.busy;
        end
        chk1("abort_quiet", seen, 1'b0);
        accept_op(32'd6, 32'hFFFF_FFF9, w);
        run_op(32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 0, 1'b0, '0, '0);

        // Asynchronous reset in the middle of RUN.
        accept_op(32'h0001_2345, 32'hFFFF_FFFF, w);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_in_ready", bus_if.in_ready, 1'b1);
        chk1("arst_out_valid", bus_if.out_valid, 1'b0);
        chk1("arst_busy", bus_if.busy, 1'b0);
        chk1("arst_clr", bus_if.spm_clr, 1'b0);
        chk1("arst_en", bus_if.spm_en, 1'b0);
        chk1("arst_ybit", bus_if.spm_y_bit, 1'b0);
        chkw("arst_out_p", bus_if.out_p, 64'h0);
        chkw("arst_spm_x", 64'(bus_if.spm_x), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        accept_op(vecs[0].x, vecs[0].y, w);
        run_op(vecs[0].y, vecs[0].p, 0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_controller.md
Name: spm_controller

Overview:
- Sequencing controller for the 32-bit signed serial-parallel multiplier (SPM) datapath, which is built from full-adder cells.
- Accepts an operand pair over a valid/ready handshake and loads the multiplicand into the datapath's parallel input.
- Streams the multiplier LSB-first, sign-extended, over 2*WIDTH cycles and collects the serial product bits into a 2*WIDTH-bit result.
- Presents the result over a valid/ready handshake. Sits between the bus-side requester and the SPM array.

Parameters:
- WIDTH, 32: operand width in bits; product width is 2*WIDTH.
- CNT_W, $clog2(2*WIDTH): width of the bit counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_x  input  WIDTH  signed multiplicand (parallel operand).
- in_y  input  WIDTH  signed multiplier (serialised operand).
- abort  input  1  synchronous cancel of an in-flight operation.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  2*WIDTH  signed product.
- busy  output  1  high in LOAD or RUN.
- spm_x  output  WIDTH  multiplicand to datapath; held for the whole operation.
- spm_clr  output  1  clears the datapath carry/sum flops.
- spm_en  output  1  datapath shift/accumulate enable.
- spm_y_bit  output  1  current serial multiplier bit.
- spm_p_bit  input  1  serial product bit from the datapath, valid in any cycle with spm_en=1.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - LOAD: spm_clr=1, spm_en=0.
  - RUN: spm_en=1.
  - DONE: out_valid=1.
- Reset (async, any state): state=IDLE; y_shift, product register, counter and spm_x all cleared to 0. Outputs: in_ready=1, out_valid=0, busy=0, spm_clr=0, spm_en=0, spm_y_bit=0, out_p=0.
- IDLE->LOAD on an edge with in_valid&in_ready:
  - in_x is latched into spm_x.
  - in_y is latched into y_shift.
  - Counter is set to 0.
- LOAD->RUN after exactly one cycle.
- In RUN, each edge:
  - product register shifts right, with spm_p_bit entering the MSB.
  - y_shift shifts right, arithmetic (MSB replicated), so spm_y_bit=in_y[k] for k<WIDTH and in_y[WIDTH-1] after that.
  - Counter increments.
  - spm_y_bit = y_shift[0] whenever in RUN, otherwise 0.
- RUN->DONE on the edge where the counter equals 2*WIDTH-1, i.e. after 2*WIDTH enabled cycles.
- Latency: out_valid rises 2*WIDTH+1 edges after the accepting edge (65 edges after acceptance for WIDTH=32).
- out_p is the product register. Its first-captured bit lands in out_p[0].
- DONE: out_p and out_valid are held stable until out_ready=1. On out_valid&out_ready: ->IDLE, with out_valid=0 on the next cycle.
- in_ready=1 only in IDLE, so no accept in the same cycle as output consumption.
- abort in LOAD or RUN: ->IDLE on the next edge, with no out_valid. The product register is discarded.
- abort in IDLE or DONE is ignored.
- spm_x is held from LOAD through DONE; it is not changed until the next accept.
- Product arithmetic is modulo 2^(2*WIDTH) two's complement. The datapath guarantees correctness with a sign-extended serial stream of 2*WIDTH bits.
- Counter never wraps in normal operation; it is cleared on each accept.

Decomposition:
- spm_pkg:
  - state enum (IDLE, LOAD, RUN, DONE).
  - SPM_WIDTH=32 default.
  - derived constant PROD_WIDTH=2*SPM_WIDTH.
- One sub-module, spm_bit_counter:
  - CNT_W-bit up-counter with clear and enable.
  - Terminal-count output at 2*WIDTH-1.
  - Async active-high reset.
- Shift registers and FSM stay in spm_controller.

Test Plan:
- Basic signed positive: x=3, y=5, datapath model attached -> out_valid after 65 edges, out_p=0x0000_0000_0000_000F; spm_en high for exactly 64 cycles.
- Mixed sign: x=6, y=-7 (0xFFFF_FFF9) -> out_p=0xFFFF_FFFF_FFFF_FFD6; spm_y_bit=1 for cycles 32..63.
- Extreme: x=y=0x8000_0000 -> out_p=0x4000_0000_0000_0000. Also x=0x7FFF_FFFF, y=-1 -> out_p=0xFFFF_FFFF_8000_0001.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> out_p stable and in_ready=0 throughout; in_valid asserted during DONE is not accepted; IDLE one cycle after out_ready.
- Abort/reset mid-run:
  - abort at RUN cycle 20 -> IDLE next edge, out_valid never asserts, a new operation then completes correctly.
  - rst asserted asynchronously mid-RUN -> all outputs immediately at reset values.
- Back-to-back: two operations, the second in_valid held continuously -> accept occurs the edge after IDLE is entered; both products correct.
